// File: rtl/carbon_memmap_pkg.sv
// Carbon system memory map: MMIO register offsets, signature value and shared MMIO types.
package carbon_memmap_pkg;

  localparam int unsigned CARBON_ADDR_W = 32;
  localparam int unsigned CARBON_DATA_W = 32;

  localparam logic [CARBON_ADDR_W-1:0] CARBON_MMIO_OFF_SIGNATURE = 32'h0000_0000;
  localparam logic [CARBON_ADDR_W-1:0] CARBON_MMIO_OFF_POWEROFF  = 32'h0000_0004;
  localparam logic [CARBON_ADDR_W-1:0] CARBON_MMIO_OFF_UART_TX   = 32'h0000_0008;

  localparam logic [CARBON_DATA_W-1:0] CARBON_MMIO_SIGNATURE_VALUE = 32'h4342_4E31;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_TXWAIT = 2'd1,
    ST_RESP   = 2'd2
  } mmio_state_e;

  typedef struct packed {
    logic [CARBON_DATA_W-1:0] rdata;
    logic                     err;
  } mmio_rsp_t;

endpackage

// File: rtl/carbon_byte_fifo.sv
// Byte FIFO with registered count; a push into an empty FIFO is visible only on the next cycle.
module carbon_byte_fifo #(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [7:0]    push_data,
  input  logic          pop,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count,
  output logic [7:0]    head
);

  logic [7:0]    mem_q [DEPTH];
  logic [7:0]    mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  // Pointers wrap naturally since DEPTH is a power of two.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/carbon_sys_mmio.sv
// System MMIO block: signature, sticky poweroff register and UART TX byte stream
// behind a single-outstanding request/response port.
module carbon_sys_mmio
  import carbon_memmap_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_F000,
  parameter logic [31:0] ADDR_MASK = 32'hFFFF_FF00,
  parameter logic [31:0] SIGNATURE = CARBON_MMIO_SIGNATURE_VALUE,
  parameter int unsigned TX_DEPTH  = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        req_write,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        poweroff,
  output logic [7:0]  poweroff_code,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [7:0]  tx_data
);

  localparam int unsigned CNT_W = $clog2(TX_DEPTH + 1);

  mmio_state_e state_q, state_d;
  mmio_rsp_t   rsp_q, rsp_d;
  logic        req_ready_q, req_ready_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        poweroff_q, poweroff_d;
  logic [7:0]  code_q, code_d;
  logic [7:0]  tx_byte_q, tx_byte_d;

  logic             push_c, pop_c, space_c, in_win_c;
  logic             fifo_full_c, fifo_empty_c;
  logic [7:0]       push_data_c, fifo_head_c;
  logic [CNT_W-1:0] fifo_count_c;
  logic [31:0]      offset_c;
  logic             unused_wdata_hi_c;

  assign unused_wdata_hi_c = ^req_wdata[31:8];
  assign offset_c = req_addr & ~ADDR_MASK;
  assign in_win_c = ((req_addr & ADDR_MASK) == BASE_ADDR);
  assign pop_c    = !fifo_empty_c && tx_ready;
  assign space_c  = !fifo_full_c || pop_c;

  carbon_byte_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push_c),
    .push_data (push_data_c),
    .pop       (pop_c),
    .full      (fifo_full_c),
    .empty     (fifo_empty_c),
    .count     (fifo_count_c),
    .head      (fifo_head_c)
  );

  // Response is decoded at acceptance; only a blocked UART push defers it via TXWAIT.
  always_comb begin
    state_d     = state_q;
    rsp_d       = rsp_q;
    rsp_valid_d = rsp_valid_q;
    poweroff_d  = poweroff_q;
    code_d      = code_q;
    tx_byte_d   = tx_byte_q;
    push_c      = 1'b0;
    push_data_c = tx_byte_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid && req_ready_q) begin
          state_d     = ST_RESP;
          rsp_valid_d = 1'b1;
          rsp_d       = '{rdata: '0, err: 1'b0};
          if (!in_win_c) begin
            rsp_d.err = 1'b1;
          end else begin
            case (offset_c)
              CARBON_MMIO_OFF_SIGNATURE: begin
                if (!req_write) rsp_d.rdata = SIGNATURE;
              end
              CARBON_MMIO_OFF_POWEROFF: begin
                if (req_write) begin
                  if (!poweroff_q) begin
                    poweroff_d = 1'b1;
                    code_d     = req_wdata[7:0];
                  end
                end else begin
                  rsp_d.rdata = {23'b0, poweroff_q, code_q};
                end
              end
              CARBON_MMIO_OFF_UART_TX: begin
                if (req_write) begin
                  tx_byte_d = req_wdata[7:0];
                  if (space_c) begin
                    push_c      = 1'b1;
                    push_data_c = req_wdata[7:0];
                  end else begin
                    state_d     = ST_TXWAIT;
                    rsp_valid_d = 1'b0;
                  end
                end else begin
                  rsp_d.rdata = 32'(fifo_count_c);
                end
              end
              default: rsp_d.err = 1'b1;
            endcase
          end
        end
      end
      ST_TXWAIT: begin
        if (space_c) begin
          push_c      = 1'b1;
          state_d     = ST_RESP;
          rsp_valid_d = 1'b1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    req_ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_q       <= '{rdata: '0, err: 1'b0};
      poweroff_q  <= 1'b0;
      code_q      <= '0;
      tx_byte_q   <= '0;
    end else begin
      state_q     <= state_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_q       <= rsp_d;
      poweroff_q  <= poweroff_d;
      code_q      <= code_d;
      tx_byte_q   <= tx_byte_d;
    end
  end

  assign req_ready     = req_ready_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_rdata     = rsp_q.rdata;
  assign rsp_err       = rsp_q.err;
  assign poweroff      = poweroff_q;
  assign poweroff_code = code_q;
  assign tx_valid      = !fifo_empty_c;
  assign tx_data       = fifo_head_c;

endmodule

// File: tb/tb_carbon_sys_mmio.sv
// Bench for carbon_sys_mmio: directed table, hand sequences and random traffic against a queue model.
module tb_carbon_sys_mmio;

  localparam logic [31:0] BASE  = 32'h0000_F000;
  localparam logic [31:0] MASK  = 32'hFFFF_FF00;
  localparam logic [31:0] SIG   = 32'h4342_4E31;
  localparam int          DEPTH = 4;

  logic        clk, rst_n;
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic        poweroff;
  logic [7:0]  poweroff_code;
  logic        tx_valid, tx_ready;
  logic [7:0]  tx_data;

  carbon_sys_mmio #(
    .BASE_ADDR (BASE),
    .ADDR_MASK (MASK),
    .SIGNATURE (SIG),
    .TX_DEPTH  (DEPTH)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_addr      (req_addr),
    .req_write     (req_write),
    .req_wdata     (req_wdata),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_rdata     (rsp_rdata),
    .rsp_err       (rsp_err),
    .poweroff      (poweroff),
    .poweroff_code (poweroff_code),
    .tx_valid      (tx_valid),
    .tx_ready      (tx_ready),
    .tx_data       (tx_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [31:0] wdata;
    int          hold;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  int          vecs = 0;
  int          errs = 0;
  logic [7:0]  m_q[$];
  logic        m_po;
  logic [7:0]  m_code;
  int          cnt_pre;
  bit          pop_now, space_pre;
  bit          tx_rand, tx_fixed;
  vec_t        tbl[12];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
    tx_ready = tx_rand ? 1'($urandom_range(0, 1)) : tx_fixed;
  endtask

  task automatic set_tx(input bit v);
    tx_fixed = v;
    tx_ready = v;
  endtask

  // Observe mid-cycle: check the tx stream against the model and note the pre-edge FIFO state.
  task automatic obs();
    @(negedge clk);
    cnt_pre = m_q.size();
    pop_now = tx_valid && tx_ready;
    chk("tx_valid", 32'(tx_valid), 32'(cnt_pre != 0));
    if (pop_now && cnt_pre != 0) chk("tx_data", 32'(tx_data), 32'(m_q[0]));
    space_pre = (cnt_pre < DEPTH) || pop_now;
  endtask

  task automatic commit(input bit push, input logic [7:0] b);
    if (pop_now && m_q.size() != 0) void'(m_q.pop_front());
    if (push) m_q.push_back(b);
  endtask

  task automatic model_accept(input logic [31:0] addr, input logic wr, input logic [31:0] wd,
                              output logic [31:0] rd, output logic err, output bit need_push);
    logic [31:0] off;
    off = addr & ~MASK;
    rd = '0;
    err = 1'b0;
    need_push = 1'b0;
    if ((addr & MASK) != BASE) err = 1'b1;
    else if (off == 32'h0) begin
      if (!wr) rd = SIG;
    end else if (off == 32'h4) begin
      if (wr) begin
        if (!m_po) begin
          m_po = 1'b1;
          m_code = wd[7:0];
        end
      end else rd = {23'b0, m_po, m_code};
    end else if (off == 32'h8) begin
      if (wr) need_push = 1'b1;
      else rd = 32'(cnt_pre);
    end else err = 1'b1;
  endtask

  // One complete transaction; returns the response seen and the number of TXWAIT cycles.
  task automatic xact(input logic [31:0] addr, input logic wr, input logic [31:0] wd,
                      input int hold, input int rel_after,
                      output logic [31:0] got_rd, output logic got_err, output int nwait);
    logic [31:0] exp_rd;
    logic        exp_err;
    bit          acc, need_push, waiting;
    acc = 0; waiting = 0; need_push = 0;
    exp_rd = '0; exp_err = 1'b0;
    got_rd = 'x; got_err = 1'bx; nwait = 0;
    req_addr = addr; req_write = wr; req_wdata = wd; req_valid = 1'b1;
    for (int c = 0; c < 200 && !acc; c++) begin
      obs();
      if (c == 0) begin
        chk("idle_req_ready", 32'(req_ready), 32'd1);
        chk("idle_rsp_valid", 32'(rsp_valid), 32'd0);
      end
      if (req_ready) begin
        acc = 1;
        model_accept(addr, wr, wd, exp_rd, exp_err, need_push);
      end
      commit(acc && need_push && space_pre, wd[7:0]);
      waiting = acc && need_push && !space_pre;
      adv();
    end
    req_valid = 1'b0;
    chk("accepted", 32'(acc), 32'd1);
    if (!acc) return;
    while (waiting && nwait < 200) begin
      if (nwait == rel_after) set_tx(1'b1);
      obs();
      chk("txwait_req_ready", 32'(req_ready), 32'd0);
      chk("txwait_rsp_valid", 32'(rsp_valid), 32'd0);
      if (space_pre) begin
        commit(1'b1, wd[7:0]);
        waiting = 0;
      end else commit(1'b0, 8'h0);
      adv();
      nwait++;
    end
    if (need_push) chk("txwait_exit", 32'(waiting), 32'd0);
    if (waiting) return;
    for (int h = 0; h <= hold; h++) begin
      if (h == hold) rsp_ready = 1'b1;
      obs();
      if (h == 0) begin
        got_rd = rsp_rdata;
        got_err = rsp_err;
      end
      chk("rsp_valid", 32'(rsp_valid), 32'd1);
      chk("rsp_rdata", rsp_rdata, exp_rd);
      chk("rsp_err", 32'(rsp_err), 32'(exp_err));
      chk("rsp_req_ready", 32'(req_ready), 32'd0);
      commit(1'b0, 8'h0);
      adv();
    end
    rsp_ready = 1'b0;
  endtask

  task automatic drain();
    set_tx(1'b1);
    for (int c = 0; c < 100 && m_q.size() != 0; c++) begin
      obs();
      commit(1'b0, 8'h0);
      adv();
    end
    chk("drain_empty", 32'(m_q.size()), 32'd0);
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    int          nw;
    logic [31:0] a;
    rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; req_write = 1'b0; req_wdata = '0;
    rsp_ready = 1'b0; tx_ready = 1'b0; tx_rand = 0; tx_fixed = 0;
    m_po = 1'b0; m_code = '0;

    tbl[0]  = '{32'h0000_F000, 1'b0, 32'h0,         0, SIG,          1'b0};
    tbl[1]  = '{32'h0000_F000, 1'b1, 32'h1234_5678, 1, 32'h0,        1'b0};
    tbl[2]  = '{32'h0000_F00C, 1'b0, 32'h0,         0, 32'h0,        1'b1};
    tbl[3]  = '{32'h0001_F000, 1'b0, 32'h0,         2, 32'h0,        1'b1};
    tbl[4]  = '{32'h0000_F004, 1'b0, 32'h0,         0, 32'h0,        1'b0};
    tbl[5]  = '{32'h0000_F008, 1'b0, 32'h0,         0, 32'h0,        1'b0};
    tbl[6]  = '{32'h0000_F004, 1'b1, 32'h0000_0107, 0, 32'h0,        1'b0};
    tbl[7]  = '{32'h0000_F004, 1'b1, 32'h0000_0055, 1, 32'h0,        1'b0};
    tbl[8]  = '{32'h0000_F004, 1'b0, 32'h0,         0, 32'h0000_0107, 1'b0};
    tbl[9]  = '{32'h0000_F010, 1'b1, 32'h0000_00AA, 0, 32'h0,        1'b1};
    tbl[10] = '{32'h0000_E008, 1'b1, 32'h0000_0041, 0, 32'h0,        1'b1};
    tbl[11] = '{32'h0000_F0FC, 1'b0, 32'h0,         0, 32'h0,        1'b1};

    repeat (2) @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_poweroff", 32'(poweroff), 32'd0);
    chk("rst_code", 32'(poweroff_code), 32'd0);
    chk("rst_tx_valid", 32'(tx_valid), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'd0);
    rst_n = 1'b1;
    set_tx(1'b1);
    adv();

    for (int i = 0; i < 12; i++) begin
      xact(tbl[i].addr, tbl[i].wr, tbl[i].wdata, tbl[i].hold, -1, rd, er, nw);
      chk($sformatf("tbl%0d_rdata", i), rd, tbl[i].exp_rdata);
      chk($sformatf("tbl%0d_err", i), 32'(er), 32'(tbl[i].exp_err));
    end
    chk("poweroff_set", 32'(poweroff), 32'd1);
    chk("poweroff_code_first", 32'(poweroff_code), 32'h07);

    // FIFO fills with the consumer stalled; the fifth byte waits until the first pop.
    set_tx(1'b0);
    for (int i = 0; i < 4; i++) xact(32'h0000_F008, 1'b1, 32'(8'h41 + i), 0, -1, rd, er, nw);
    xact(32'h0000_F008, 1'b0, 32'h0, 0, -1, rd, er, nw);
    chk("count_full", rd, 32'd4);
    xact(32'h0000_F008, 1'b1, 32'h45, 0, 3, rd, er, nw);
    chk("txwait_cycles", 32'(nw), 32'd4);
    drain();
    xact(32'h0000_F008, 1'b0, 32'h0, 0, -1, rd, er, nw);
    chk("count_after_drain", rd, 32'd0);

    // Long response stall while the stream keeps draining.
    set_tx(1'b0);
    for (int i = 0; i < 3; i++) xact(32'h0000_F008, 1'b1, 32'(8'h60 + i), 0, -1, rd, er, nw);
    set_tx(1'b1);
    xact(32'h0000_F000, 1'b0, 32'h0, 5, -1, rd, er, nw);
    chk("stall_sig", rd, SIG);
    xact(32'h0000_F008, 1'b0, 32'h0, 0, -1, rd, er, nw);
    chk("stall_drained", rd, 32'd0);

    // Reset while a write sits in TXWAIT behind four queued bytes.
    set_tx(1'b0);
    for (int i = 0; i < 4; i++) xact(32'h0000_F008, 1'b1, 32'(8'h70 + i), 0, -1, rd, er, nw);
    req_addr = 32'h0000_F008; req_write = 1'b1; req_wdata = 32'h74; req_valid = 1'b1;
    obs();
    chk("rst_seq_accept", 32'(req_ready), 32'd1);
    commit(1'b0, 8'h0);
    adv();
    req_valid = 1'b0;
    obs();
    chk("rst_seq_txwait", 32'(req_ready), 32'd0);
    commit(1'b0, 8'h0);
    adv();
    rst_n = 1'b0;
    #2;
    chk("midrst_tx_valid", 32'(tx_valid), 32'd0);
    chk("midrst_req_ready", 32'(req_ready), 32'd0);
    chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    m_q.delete();
    m_po = 1'b0;
    m_code = '0;
    @(negedge clk);
    rst_n = 1'b1;
    set_tx(1'b1);
    adv();
    for (int c = 0; c < 5; c++) begin
      obs();
      chk("postrst_rsp_valid", 32'(rsp_valid), 32'd0);
      commit(1'b0, 8'h0);
      adv();
    end
    xact(32'h0000_F008, 1'b0, 32'h0, 0, -1, rd, er, nw);
    chk("postrst_count", rd, 32'd0);
    xact(32'h0000_F004, 1'b0, 32'h0, 0, -1, rd, er, nw);
    chk("postrst_poweroff_reg", rd, 32'd0);

    // Random traffic against the model with a randomly stalling consumer.
    tx_rand = 1;
    for (int n = 0; n < 80; n++) begin
      case ($urandom_range(0, 6))
        0: a = 32'h0000_F000;
        1: a = 32'h0000_F004;
        2, 3: a = 32'h0000_F008;
        4: a = BASE | 32'({$urandom_range(0, 63), 2'b00});
        5: a = 32'h0001_F008;
        default: a = 32'($urandom);
      endcase
      xact(a, 1'($urandom_range(0, 1)), 32'($urandom), $urandom_range(0, 2), -1, rd, er, nw);
    end
    tx_rand = 0;
    drain();
    chk("rand_poweroff", 32'(poweroff), 32'(m_po));
    chk("rand_code", 32'(poweroff_code), 32'(m_code));

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
